gt_rx_comma_align: RTL and testbench

- Sits directly downstream of one GT channel's RX user interface, in the RX user-clock domain.
- Consumes the 32-bit RX data word, the 4 K-char flags and the byte-align indicator.
- Locates the K28.5 comma lane and locks to it through a hysteresis state machine.
- Outputs a lane-realigned 32-bit word with the comma in byte 0, plus lock status, for the frame parser downstream.

---
 rtl/gt_rx_comma_align.sv | 200 ++++++++++++++++++++
 tb/tb_gt_rx_comma_align.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gt_rx_comma_align.sv
// gt_rx_comma_align
// Finds the K28.5 comma lane in the GT RX word, locks to it through a
// HUNT/CHECK/LOCKED hysteresis FSM and re-slices the byte stream so that
// the comma lands in byte 0 of o_data.
// Optional statistics counters are compiled in with `define GT_RX_ALIGN_STAT_EN.
module gt_rx_comma_align #(
    parameter logic [7:0]  COMMA_BYTE = 8'hBC,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned LOSS_CNT   = 3
) (
    input  logic        i_rx_clk,
    input  logic        i_rx_rst,
    input  logic [31:0] i_rx_data,
    input  logic [3:0]  i_rx_char,
    input  logic        i_rx_ByteAlign,
    output logic [31:0] o_data,
    output logic [3:0]  o_char,
    output logic        o_valid,
    output logic        o_lock,
    output logic [1:0]  o_lane
`ifdef GT_RX_ALIGN_STAT_EN
    ,
    output logic [15:0] o_unlock_cnt,
    output logic [15:0] o_lane_err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LP_LOCK = 4'(LOCK_CNT);
    localparam logic [3:0] LP_LOSS = 4'(LOSS_CNT);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_offset, w_offset_nxt;
    logic [3:0]  r_lock_cnt, w_lock_cnt_nxt;
    logic [3:0]  r_err_cnt, w_err_cnt_nxt;
    logic [31:0] r_prev_data;
    logic [3:0]  r_prev_char;

    logic [3:0]  w_hit;
    logic        w_det;
    logic [1:0]  w_det_lane;
    logic [3:0]  w_lock_inc;
    logic [3:0]  w_err_inc;
    logic [63:0] w_cat_data;
    logic [7:0]  w_cat_char;

    // Per-lane comma hit: byte value and its K flag must both match
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_hit
            assign w_hit[g] = (i_rx_data[8*g +: 8] == COMMA_BYTE) && i_rx_char[g];
        end
    endgenerate

    // Lowest-index hit wins when several lanes carry a comma
    always_comb begin
        w_det      = 1'b0;
        w_det_lane = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (w_hit[n]) begin
                w_det      = 1'b1;
                w_det_lane = 2'(n);
            end
        end
    end

    // Saturating increments so the 4-bit counters never wrap
    assign w_lock_inc = (r_lock_cnt == 4'hF) ? r_lock_cnt : r_lock_cnt + 4'd1;
    assign w_err_inc  = (r_err_cnt  == 4'hF) ? r_err_cnt  : r_err_cnt  + 4'd1;

    // Next-state logic; loss of byte alignment overrides every comma rule
    always_comb begin
        w_state_nxt    = r_state;
        w_offset_nxt   = r_offset;
        w_lock_cnt_nxt = r_lock_cnt;
        w_err_cnt_nxt  = r_err_cnt;
        if (!i_rx_ByteAlign) begin
            w_state_nxt    = ST_HUNT;
            w_lock_cnt_nxt = 4'd0;
            w_err_cnt_nxt  = 4'd0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_det) begin
                        w_offset_nxt   = w_det_lane;
                        w_lock_cnt_nxt = 4'd1;
                        if (LP_LOCK == 4'd1) begin
                            w_state_nxt   = ST_LOCKED;
                            w_err_cnt_nxt = 4'd0;
                        end else begin
                            w_state_nxt = ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_det) begin
                        if (w_det_lane == r_offset) begin
                            w_lock_cnt_nxt = w_lock_inc;
                            if (w_lock_inc >= LP_LOCK) begin
                                w_state_nxt   = ST_LOCKED;
                                w_err_cnt_nxt = 4'd0;
                            end
                        end else begin
                            // Comma moved: restart qualification on the new lane
                            w_offset_nxt   = w_det_lane;
                            w_lock_cnt_nxt = 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_det) begin
                        if (w_det_lane == r_offset) begin
                            w_err_cnt_nxt = 4'd0;
                        end else if (w_err_inc >= LP_LOSS) begin
                            // Offset is held so the stream stays sliced the same way
                            w_state_nxt    = ST_HUNT;
                            w_lock_cnt_nxt = 4'd0;
                            w_err_cnt_nxt  = 4'd0;
                        end else begin
                            w_err_cnt_nxt = w_err_inc;
                        end
                    end
                end
                default: begin
                    w_state_nxt    = ST_HUNT;
                    w_lock_cnt_nxt = 4'd0;
                    w_err_cnt_nxt  = 4'd0;
                end
            endcase
        end
    end

    // FSM state, offset and counters
    always_ff @(posedge i_rx_clk) begin
        if (i_rx_rst) begin
            r_state    <= ST_HUNT;
            r_offset   <= 2'd0;
            r_lock_cnt <= 4'd0;
            r_err_cnt  <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_offset   <= w_offset_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    // Previous word joined with the current one gives a 64-bit window to slice from
    assign w_cat_data = {i_rx_data, r_prev_data};
    assign w_cat_char = {i_rx_char, r_prev_char};

    // Realignment datapath and registered status outputs
    always_ff @(posedge i_rx_clk) begin
        if (i_rx_rst) begin
            r_prev_data <= 32'd0;
            r_prev_char <= 4'd0;
            o_data      <= 32'd0;
            o_char      <= 4'd0;
            o_valid     <= 1'b0;
            o_lock      <= 1'b0;
            o_lane      <= 2'd0;
        end else begin
            r_prev_data <= i_rx_data;
            r_prev_char <= i_rx_char;
            o_data      <= w_cat_data[{r_offset, 3'b000} +: 32];
            o_char      <= w_cat_char[r_offset +: 4];
            o_valid     <= (w_state_nxt == ST_LOCKED);
            o_lock      <= (w_state_nxt == ST_LOCKED);
            o_lane      <= r_offset;
        end
    end

`ifdef GT_RX_ALIGN_STAT_EN
    logic w_unlock_evt;
    logic w_lane_err_evt;

    assign w_unlock_evt   = (r_state == ST_LOCKED) && (w_state_nxt == ST_HUNT);
    assign w_lane_err_evt = (r_state == ST_LOCKED) && i_rx_ByteAlign && w_det &&
                            (w_det_lane != r_offset);

    // Saturating event counters, cleared only by reset
    always_ff @(posedge i_rx_clk) begin
        if (i_rx_rst) begin
            o_unlock_cnt   <= 16'd0;
            o_lane_err_cnt <= 16'd0;
        end else begin
            if (w_unlock_evt && (o_unlock_cnt != 16'hFFFF))
                o_unlock_cnt <= o_unlock_cnt + 16'd1;
            if (w_lane_err_evt && (o_lane_err_cnt != 16'hFFFF))
                o_lane_err_cnt <= o_lane_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gt_rx_comma_align.sv
// Testbench for gt_rx_comma_align: directed scenarios plus random traffic,
// all compared every cycle against a byte-stream reference model.
module tb_gt_rx_comma_align;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d;
    logic [3:0]  c;
    logic        ba;
    logic [31:0] o_data;
    logic [3:0]  o_char;
    logic        o_valid, o_lock;
    logic [1:0]  o_lane;
`ifdef GT_RX_ALIGN_STAT_EN
    logic [15:0] o_unlock_cnt, o_lane_err_cnt;
`endif

    always #5 clk = ~clk;

    gt_rx_comma_align #(.COMMA_BYTE(COMMA), .LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
        .i_rx_clk       (clk),
        .i_rx_rst       (rst),
        .i_rx_data      (d),
        .i_rx_char      (c),
        .i_rx_ByteAlign (ba),
        .o_data         (o_data),
        .o_char         (o_char),
        .o_valid        (o_valid),
        .o_lock         (o_lock),
        .o_lane         (o_lane)
`ifdef GT_RX_ALIGN_STAT_EN
        ,
        .o_unlock_cnt   (o_unlock_cnt),
        .o_lane_err_cnt (o_lane_err_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 searching, 1 qualifying, 2 locked
    int          m_mode, m_lane, m_good, m_bad;
    logic [7:0]  m_pb [4];
    logic        m_pk [4];
    int          m_unl, m_lerr;
    logic [31:0] e_data;
    logic [3:0]  e_char;
    logic        e_lock;
    logic [1:0]  e_lane;

    task automatic model(input logic r, input logic [31:0] dd, input logic [3:0] cc, input logic b);
        logic [7:0] sb [8];
        logic       sk [8];
        int         hit;
        bit         was_locked;
        if (r) begin
            m_mode = 0; m_lane = 0; m_good = 0; m_bad = 0; m_unl = 0; m_lerr = 0;
            for (int i = 0; i < 4; i++) begin m_pb[i] = 8'd0; m_pk[i] = 1'b0; end
            e_data = 0; e_char = 0; e_lock = 0; e_lane = 0;
            return;
        end
        // Byte stream: four older bytes, then the four bytes just received
        for (int i = 0; i < 4; i++) begin
            sb[i] = m_pb[i]; sk[i] = m_pk[i];
            sb[i+4] = dd[8*i +: 8]; sk[i+4] = cc[i];
        end
        for (int i = 0; i < 4; i++) begin
            e_data[8*i +: 8] = sb[m_lane + i];
            e_char[i]        = sk[m_lane + i];
        end
        e_lane = 2'(m_lane);
        hit = -1;
        for (int i = 3; i >= 0; i--) if (dd[8*i +: 8] == COMMA && cc[i]) hit = i;
        was_locked = (m_mode == 2);
        if (!b) begin
            m_mode = 0; m_good = 0; m_bad = 0;
        end else if (hit >= 0) begin
            if (m_mode == 0) begin
                m_lane = hit; m_good = 1;
                m_mode = (LOCK_N == 1) ? 2 : 1;
                if (m_mode == 2) m_bad = 0;
            end else if (m_mode == 1) begin
                if (hit == m_lane) begin
                    if (m_good < 15) m_good++;
                    if (m_good >= LOCK_N) begin m_mode = 2; m_bad = 0; end
                end else begin
                    m_lane = hit; m_good = 1;
                end
            end else begin
                if (hit == m_lane) m_bad = 0;
                else begin
                    if (m_lerr < 65535) m_lerr++;
                    if (m_bad < 15) m_bad++;
                    if (m_bad >= LOSS_N) begin m_mode = 0; m_good = 0; m_bad = 0; end
                end
            end
        end
        if (was_locked && m_mode == 0 && m_unl < 65535) m_unl++;
        e_lock = (m_mode == 2);
        for (int i = 0; i < 4; i++) begin m_pb[i] = dd[8*i +: 8]; m_pk[i] = cc[i]; end
    endtask

    task automatic step(input logic r, input logic [31:0] dd, input logic [3:0] cc, input logic b);
        rst = r; d = dd; c = cc; ba = b;
        model(r, dd, cc, b);
        @(posedge clk);
        #1;
        chk("data", o_data, e_data);
        chk("char", {28'd0, o_char}, {28'd0, e_char});
        chk("valid", {31'd0, o_valid}, {31'd0, e_lock});
        chk("lock", {31'd0, o_lock}, {31'd0, e_lock});
        chk("lane", {30'd0, o_lane}, {30'd0, e_lane});
`ifdef GT_RX_ALIGN_STAT_EN
        chk("unlock_cnt", {16'd0, o_unlock_cnt}, 32'(m_unl));
        chk("lane_err_cnt", {16'd0, o_lane_err_cnt}, 32'(m_lerr));
`endif
    endtask

    // Random word with commas on the lanes in mask and no stray comma bytes
    function automatic logic [31:0] mkw(input logic [3:0] mask);
        logic [31:0] w;
        logic [7:0]  v;
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            if (v == COMMA) v = 8'h00;
            w[8*i +: 8] = mask[i] ? COMMA : v;
        end
        return w;
    endfunction

    task automatic cw(input logic [3:0] mask);
        step(1'b0, mkw(mask), mask | (4'($urandom) & ~mask), 1'b1);
    endtask

    task automatic do_rst();
        step(1'b1, 32'($urandom), 4'($urandom), 1'b1);
        step(1'b1, 32'($urandom), 4'($urandom), 1'b1);
    endtask

    initial begin
        int fav;
        rst = 1'b1; d = 0; c = 0; ba = 1'b1;
        do_rst();
        chk("rst_lock", {31'd0, o_lock}, 32'd0);
        chk("rst_data", o_data, 32'd0);

        // Lane-2 comma every 4th word
        for (int k = 0; k < 14; k++) begin
            cw((k % 4 == 0) ? 4'b0100 : 4'b0000);
            if (k == 8)  chk("tp1_nolock", {31'd0, o_lock}, 32'd0);
            if (k == 12) begin
                chk("tp1_lock", {31'd0, o_lock}, 32'd1);
                chk("tp1_lane", {30'd0, o_lane}, 32'd2);
            end
            if (k == 13) begin
                chk("tp1_byte0", {24'd0, o_data[7:0]}, {24'd0, COMMA});
                chk("tp1_k0", {31'd0, o_char[0]}, 32'd1);
            end
        end

        // Lane 1 twice then lane 3 four times
        do_rst();
        cw(4'b0010); cw(4'b0010);
        cw(4'b1000); cw(4'b1000); cw(4'b1000);
        chk("tp2_nolock", {31'd0, o_lock}, 32'd0);
        cw(4'b1000);
        chk("tp2_lock", {31'd0, o_lock}, 32'd1);
        chk("tp2_lane", {30'd0, o_lane}, 32'd3);

        // Locked on lane 0; err counter cleared by a good comma, then three wrong
        do_rst();
        repeat (4) cw(4'b0001);
        cw(4'b0100); cw(4'b0100); cw(4'b0001); cw(4'b0100); cw(4'b0100);
        chk("tp3_hold", {31'd0, o_lock}, 32'd1);
        cw(4'b0100);
        chk("tp3_unlock", {31'd0, o_lock}, 32'd0);
        chk("tp3_invalid", {31'd0, o_valid}, 32'd0);
        repeat (4) cw(4'b0001);
        cw(4'b0100); cw(4'b0001);
        chk("tp3_single", {31'd0, o_lock}, 32'd1);

        // Byte-align drop, then relock needs four fresh commas
        step(1'b0, mkw(4'b0000), 4'b0000, 1'b0);
        chk("tp4_drop", {31'd0, o_lock}, 32'd0);
        repeat (3) cw(4'b0001);
        chk("tp4_wait", {31'd0, o_lock}, 32'd0);
        cw(4'b0001);
        chk("tp4_relock", {31'd0, o_lock}, 32'd1);

        // Simultaneous lanes 1 and 3, then a known pattern through offset 1
        do_rst();
        cw(4'b1010);
        cw(4'b0000);
        chk("tp5_lane", {30'd0, o_lane}, 32'd1);
        step(1'b0, 32'h03020100, 4'b0000, 1'b1);
        step(1'b0, 32'h07060504, 4'b0000, 1'b1);
        chk("tp5_data", o_data, 32'h04030201);

`ifdef GT_RX_ALIGN_STAT_EN
        do_rst();
        repeat (4) cw(4'b0001);
        cw(4'b0010); cw(4'b0010); cw(4'b0001);
        step(1'b0, mkw(4'b0000), 4'b0000, 1'b0);
        repeat (4) cw(4'b0001);
        repeat (3) cw(4'b0100);
        chk("st_unlock", {16'd0, o_unlock_cnt}, 32'd2);
        chk("st_lerr", {16'd0, o_lane_err_cnt}, 32'd5);
        do_rst();
        chk("st_unlock_rst", {16'd0, o_unlock_cnt}, 32'd0);
        chk("st_lerr_rst", {16'd0, o_lane_err_cnt}, 32'd0);
`endif

        // Random traffic: mostly a favoured lane, with lane hops, align drops, resets
        fav = 0;
        for (int k = 0; k < 4000; k++) begin
            logic [3:0] mask;
            logic [31:0] w;
            logic [3:0]  cf;
            if ($urandom_range(0, 99) < 8) fav = $urandom_range(0, 3);
            mask = 4'b0000;
            if ($urandom_range(0, 99) < 45) mask[fav] = 1'b1;
            if ($urandom_range(0, 99) < 6)  mask[$urandom_range(0, 3)] = 1'b1;
            w  = mkw(mask);
            cf = mask | (4'($urandom) & ~mask);
            // Occasionally a comma byte without its K flag
            if ($urandom_range(0, 99) < 3) begin
                int l = $urandom_range(0, 3);
                w[8*l +: 8] = COMMA;
                cf[l] = 1'b0;
            end
            step(($urandom_range(0, 999) < 4) ? 1'b1 : 1'b0, w, cf,
                 ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
